// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM byte address, absorbs the ROM's
// one-cycle read latency and hands {pc, instr} to the decoder over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_halt,
  output logic              o_misalign,
  output logic [31:0]       o_fetch_cnt
);

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_VALID   = 2'd2,
    ST_STOP    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;
  logic        misalign_q, misalign_d;
  logic        out_of_range_s;

  // Any PC bit above the ROM window means the fetch would alias, so it halts instead.
  assign out_of_range_s = (pc_q >> ADDR_W) != 32'd0;

  assign o_rom_addr  = pc_q[ADDR_W-1:0];
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_halt      = halt_q;
  assign o_misalign  = misalign_q;
  assign o_fetch_cnt = cnt_q;

  // Next-state and datapath updates; a redirect overrides every state action.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    misalign_d = misalign_q;

    if (i_redirect) begin
      pc_d    = {i_redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      halt_d  = 1'b0;
      state_d = ST_ISSUE;
      if (i_redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else begin
        misalign_d = misalign_q;
      end
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (out_of_range_s) begin
            halt_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          instr_d = i_rom_data;
          opc_d   = pc_q;
          if (i_rom_data == 32'h0000_0000) begin
            halt_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            valid_d = 1'b1;
            state_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (valid_q && i_ready) begin
            valid_d = 1'b0;
            pc_d    = pc_q + 32'd4;
            cnt_d   = cnt_q + 32'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_VALID;
          end
        end
        ST_STOP: begin
          valid_d = 1'b0;
          state_d = ST_STOP;
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_ISSUE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      opc_q      <= 32'h0000_0000;
      cnt_q      <= 32'h0000_0000;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opc_q      <= opc_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
